// File: rtl/mux_sel_arb_pkg.sv
// Shared types and constants for the two-requester mux select arbiter.
package mux_sel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Round-robin pointer encoding: which side wins the next tie.
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    function automatic logic sel_for_state(arb_state_e st, logic sel_hold);
        case (st)
            GNT_A:   return SEL_A;
            GNT_B:   return SEL_B;
            default: return sel_hold;
        endcase
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_burst_cnt.sv
// Per-grant transfer counter: clear, increment, saturate at MAX_BURST-1, terminal-count flag.
module mux_sel_burst_cnt #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c = (cnt_q == CNT_LAST);
    assign cnt  = cnt_q;

    // Clear wins over increment; increment at terminal count holds (saturation).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !tc_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared 2:1 mux select with per-grant burst cap.
// Optional MUX_SEL_ARB_LOCK_EN adds a lock input that suspends the burst cap.
module mux_sel_arbiter
    import mux_sel_arb_pkg::*;
#(
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             out_ready,
`ifdef MUX_SEL_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             out_valid,
    output logic [CNT_W-1:0] burst_cnt
);

    arb_state_e state_q, state_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       sel_q, sel_d;
    logic       rr_q, rr_d;
    logic       cnt_clr, cnt_inc, cnt_tc_c;
    logic       xfer_c, lock_c;

`ifdef MUX_SEL_ARB_LOCK_EN
    assign lock_c = lock;
`else
    assign lock_c = 1'b0;
`endif

    assign out_valid = (gnt_a_q & req_a) | (gnt_b_q & req_b);
    assign xfer_c    = out_valid & out_ready;

    mux_sel_burst_cnt #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_burst_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (burst_cnt),
        .tc_c (cnt_tc_c)
    );

    // Next-state: releases hand over directly to the other side when it is waiting.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || rr_q == RR_A)) begin
                    state_d = GNT_A;
                end else if (req_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (!req_a || (xfer_c && cnt_tc_c && !lock_c)) begin
                    rr_d    = RR_B;
                    cnt_clr = 1'b1;
                    if (req_b) begin
                        state_d = GNT_B;
                    end else if (req_a) begin
                        state_d = GNT_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_inc = xfer_c;
                end
            end
            GNT_B: begin
                if (!req_b || (xfer_c && cnt_tc_c && !lock_c)) begin
                    rr_d    = RR_A;
                    cnt_clr = 1'b1;
                    if (req_a) begin
                        state_d = GNT_A;
                    end else if (req_b) begin
                        state_d = GNT_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_inc = xfer_c;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        gnt_a_d = (state_d == GNT_A);
        gnt_b_d = (state_d == GNT_B);
        sel_d   = sel_for_state(state_d, sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= SEL_B;
            rr_q    <= RR_A;
        end else begin
            state_q <= state_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign sel   = sel_q;

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select line of the shared 2:1 mux (`mux`: s==1 routes a to y, s==0 routes b to y).
- Grants one source at a time and drives `sel` to match the grant.
- Caps each grant at a programmable burst length and qualifies a single valid/ready output toward the downstream consumer of y.

Parameters:
- MAX_BURST, 4, maximum transfers per grant before forced release; legal range >= 1.
- CNT_W, $clog2(MAX_BURST+1), burst counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_a  in  1  source A requests the mux (mux input a)
- req_b  in  1  source B requests the mux (mux input b)
- out_ready  in  1  downstream accepts y this cycle
- gnt_a  out  1  A owns the mux
- gnt_b  out  1  B owns the mux
- sel  out  1  mux select; 1 = a, 0 = b
- out_valid  out  1  y carries valid data
- burst_cnt  out  CNT_W  transfers completed in current grant

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; gnt_a=gnt_b=0; sel=0; burst_cnt=0; rr pointer = A (A wins first tie).
  - Reset mid-burst aborts the grant at that edge, with no partial-state carry.
- States: IDLE, GNT_A, GNT_B. All outputs registered except out_valid.
- IDLE:
  - No request -> stay IDLE; sel holds its last value.
  - Requests present -> grant at the next edge (1-cycle request-to-grant latency).
  - Only one requester -> grant it.
  - Both requesting -> grant the rr pointer side.
  - sel updates on the same edge as gnt: GNT_A -> sel=1, GNT_B -> sel=0.
- GNT_X:
  - out_valid = gnt_x & req_x (combinational).
  - Transfer = out_valid & out_ready; each transfer increments burst_cnt.
  - Release when either holds:
    - req_x=0 at a clock edge: the grant ends; no transfer that cycle.
    - A transfer occurs with burst_cnt==MAX_BURST-1: the final transfer completes, then the grant releases.
  - On release:
    - rr pointer moves to the other side; burst_cnt=0.
    - Other side requesting -> go directly to its GNT state, no idle bubble.
    - Otherwise, same side still requesting -> re-grant same side (new burst).
    - Otherwise -> IDLE.
- No grant change while out_valid=1 and out_ready=0 (transfer pending); burst_cnt holds.
- Invariants: gnt_a & gnt_b never both 1; sel==1 iff gnt_a whenever any gnt is 1.
- MAX_BURST=1: every transfer releases; two continuous requesters alternate A,B,A,B each transfer.
- burst_cnt never exceeds MAX_BURST-1 as observed.

Optional Feature:
- Macro MUX_SEL_ARB_LOCK_EN.
- Defined:
  - Adds input `lock` (1 bit).
  - While lock=1 in GNT_X, the MAX_BURST limit is ignored; burst_cnt saturates at MAX_BURST-1.
  - Release then happens only on req_x=0.
  - lock is ignored in IDLE.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Package mux_sel_arb_pkg:
  - State enum arb_state_e {IDLE, GNT_A, GNT_B}.
  - Constants SEL_A=1'b1, SEL_B=1'b0.
- One natural sub-module, mux_sel_burst_cnt: increment, clear, saturate, and terminal-count flag.
- The top instantiates the existing `mux` only in the bench, not inside this block.

Test Plan:
- Reset, then req_a=1 only, out_ready=1 -> gnt_a=1, sel=1 one cycle later; 4 transfers, release, re-grant A with burst_cnt=0.
- req_a=req_b=1 continuous, out_ready=1, MAX_BURST=4 -> grants alternate A(4),B(4),A(4); no idle cycle between grants; sel toggles 1,0,1.
- GNT_B active, out_ready=0 for 3 cycles with req_a=1 -> gnt_b and sel=0 hold, burst_cnt frozen; resumes when out_ready=1.
- req_a drops after 2 transfers with req_b=1 -> next edge gnt_b=1, sel=0, burst_cnt=0.
- rst=1 during GNT_A with burst_cnt=2 -> next cycle gnt_a=gnt_b=0, sel=0, burst_cnt=0; A again wins a subsequent tie.
- With MUX_SEL_ARB_LOCK_EN: lock=1, both requesting -> A holds for 10 transfers, burst_cnt stuck at 3; lock=0 -> release to B after the next transfer.
